// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: op codes, FSM states, lane widths
// and the alignment rule used when a request is accepted.
package lsu_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  function automatic logic is_load(input logic [2:0] op);
    return (op <= OP_LBU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      OP_LW, OP_SW:         return (lane != 2'b00);
      OP_LH, OP_LHU, OP_SH: return lane[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a load value from a memory
// word, and merges sub-word store data into a word (little-endian lanes).
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_lane,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_store
);

  logic signed [BYTE_W-1:0] w_byte;
  logic signed [HALF_W-1:0] w_half;

  always_comb begin
    w_byte = i_word[{i_lane, 3'b000} +: BYTE_W];
    w_half = i_lane[1] ? i_word[DATA_W-1:HALF_W] : i_word[HALF_W-1:0];

    case (i_op)
      OP_LW:   o_load = i_word;
      OP_LH:   o_load = DATA_W'(w_half);
      OP_LHU:  o_load = {{(DATA_W-HALF_W){1'b0}}, w_half};
      OP_LB:   o_load = DATA_W'(w_byte);
      OP_LBU:  o_load = {{(DATA_W-BYTE_W){1'b0}}, w_byte};
      default: o_load = '0;
    endcase

    o_store = i_word;
    case (i_op)
      OP_SW: o_store = i_wdata;
      OP_SH: begin
        if (i_lane[1]) o_store[DATA_W-1:HALF_W] = i_wdata[HALF_W-1:0];
        else           o_store[HALF_W-1:0]      = i_wdata[HALF_W-1:0];
      end
      OP_SB:   o_store[{i_lane, 3'b000} +: BYTE_W] = i_wdata[BYTE_W-1:0];
      default: o_store = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: adds byte/halfword access to a word-only data memory using
// read-modify-write for sub-word stores, with a request/one-cycle-response handshake.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData
);

  state_t            r_state;
  logic [2:0]        r_op;
  logic [1:0]        r_lane;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_word_q;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_store;

  // Results are registered at the end of RD, so use the live memory word there.
  assign w_word = (r_state == RD) ? readData : r_word_q;

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_word  (w_word),
    .i_lane  (r_lane),
    .i_op    (r_op),
    .i_wdata (r_wdata),
    .o_load  (w_load),
    .o_store (w_store)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_lane     <= '0;
      r_wdata    <= '0;
      r_word_q   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      address    <= '0;
      writeData  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_op      <= req_op;
            r_lane    <= req_addr[1:0];
            r_wdata   <= req_wdata;
            req_ready <= 1'b0;
            if (is_misaligned(req_op, req_addr[1:0])) begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_op == OP_SW) begin
              r_state   <= WR;
              MemWrite  <= 1'b1;
              address   <= {req_addr[ADDR_W-1:2], 2'b00};
              writeData <= req_wdata;
            end else begin
              r_state <= RD;
              MemRead <= 1'b1;
              address <= {req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        RD: begin
          r_word_q <= readData;
          MemRead  <= 1'b0;
          if (is_load(r_op)) begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= w_load;
          end else begin
            r_state   <= WR;
            MemWrite  <= 1'b1;
            writeData <= w_store;
          end
        end
        WR: begin
          MemWrite   <= 1'b0;
          r_state    <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts load/store requests from the MIPS datapath and drives MemRead, MemWrite, address and writeData into the word-organised, 256-entry data memory.
- Adds byte and halfword access (lb, lbu, lh, lhu, sb, sh) on top of a word-only memory. Sub-word stores use read-modify-write.
- Checks alignment and returns the load result through a valid/ready request and one-cycle response handshake.

Parameters:
- ADDR_W, 32, width of request and memory address.
- DATA_W, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_op  input  3  operation: LW=000, LH=001, LHU=010, LB=011, LBU=100, SW=101, SH=110, SB=111.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data; the low byte or halfword is used for SB/SH.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  DATA_W  load result, extended per op; 0 for stores and errors.
- resp_err  output  1  misaligned access; qualified by resp_valid.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable; memory writes on the posedge while high.
- address  output  ADDR_W  word-aligned address to memory (latched addr with [1:0] forced to 0).
- writeData  output  DATA_W  word written to memory.
- readData  input  DATA_W  combinational memory read data; valid while MemRead=1.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - MemRead=0, MemWrite=0, address=0, writeData=0.
  - All latches cleared.
- Reset mid-operation: MemWrite drops immediately, so no memory write occurs on the following edge. Any pending response is discarded.
- States are IDLE, RD, WR and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch op, addr and wdata.
  - Misaligned requests go to RESP with err=1 and make no memory access. Misaligned means: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0.
  - Otherwise, loads and SH/SB go to RD; SW goes to WR.
- RD: MemRead=1 and word_q<=readData at the edge. Loads then go to RESP; SH/SB go to WR.
- WR: MemWrite=1 and writeData is the merged word. Next state is RESP.
  - SW: writeData=wdata.
  - SH: replace halfword lane addr[1] of word_q with wdata[15:0].
  - SB: replace byte lane addr[1:0] of word_q with wdata[7:0].
- RESP: resp_valid=1 for exactly one cycle; next state is IDLE.
  - resp_rdata is registered, computed from word_q:
    - LW: the whole word.
    - LH: sign-extend the selected halfword.
    - LHU: zero-extend the selected halfword.
    - LB: sign-extend the selected byte.
    - LBU: zero-extend the selected byte.
  - resp_rdata=0 for stores and errors.
- Lane ordering is little-endian: byte lane k is bits [8k+7:8k]; halfword lane 1 is bits [31:16].
- MemRead and MemWrite are never high together; both are 0 in IDLE and RESP.
- address and writeData hold their last value outside RD/WR.
- Latency in cycles from the accept edge to resp_valid high: loads 2, SW 2, SH/SB 3, error 1.
- The next request can be accepted in the cycle after RESP, since IDLE has req_ready=1.
- Throughput: one request in flight; req_valid outside IDLE is ignored and held off by req_ready=0.
- Only address bits [9:2] reach memory meaningfully. Higher bits pass through untouched; no range error is raised.

Decomposition:
- Package lsu_pkg holds:
  - the op encoding constants (OP_LW..OP_SB);
  - the state enum (IDLE, RD, WR, RESP);
  - helper constants BYTE_W=8, HALF_W=16.
- One natural sub-module, lsu_lane_align, is purely combinational:
  - Inputs: word_q, addr[1:0], op, wdata.
  - Outputs: the extracted/extended load value and the merged store word.
  - The FSM stays in load_store_unit.

Test Plan:
- After reset, SW addr=0x10 wdata=0xDEADBEEF -> one WR cycle with address=0x10, writeData=0xDEADBEEF; resp_valid 2 cycles after accept; err=0.
- With mem[0x10]=0xDEADBEEF, run LB/LBU/LH/LHU/LW.
  - LB at 0x13 -> 0xFFFFFFDE; LBU at 0x13 -> 0x000000DE.
  - LH at 0x10 -> 0xFFFFBEEF; LHU at 0x12 -> 0x0000DEAD.
  - LW at 0x10 -> 0xDEADBEEF.
- Read-modify-write with mem[0x20]=0x11223344.
  - SB addr=0x21 wdata=0xAA -> RD then WR, writeData=0x1122AA44; resp 3 cycles after accept.
  - Then SH addr=0x22 wdata=0xBEEF -> mem becomes 0xBEEFAA44.
- Misaligned: LW at 0x22 and SH at 0x05 -> resp_err=1 and resp_rdata=0 one cycle after accept. MemRead and MemWrite stay 0 throughout; memory is unchanged.
- Back-to-back: hold req_valid high with SW then LW to the same address. req_ready is low during RD/WR/RESP, and the second request is accepted in the cycle after RESP. LW returns the stored value.
- Reset mid-SB: assert reset_n=0 while in WR. MemWrite goes to 0 immediately and memory is unchanged. After release, req_ready=1 and resp_valid=0.
